serial_fifo_rx: RTL and testbench

- Receive-side counterpart of the FIFO-fed serial transmitter that drives `out_port`.
- Deserialises the single-wire frame stream (idle high, 1 start bit low, DATA_W data bits LSB first, 1 stop bit high) into words.
- Pushes each word into an internal synchronous FIFO; the local logic drains the FIFO through a read-enable interface.
- Sits at the receiving end of a board link or in a loopback test, fed directly from the transmitter's serial output.

---
 rtl/serial_fifo_rx_pkg.sv | 15 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/serial_fifo_rx.sv | 154 +++++++++++++++
 tb/tb_serial_fifo_rx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_fifo_rx_pkg.sv
// rtl/serial_fifo_rx_pkg.sv - shared state encoding and line-level constants for serial_fifo_rx
package serial_fifo_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with wrap-bit pointers and a registered pop port
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q;
  logic                do_rd, do_wr;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= do_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/serial_fifo_rx.sv
// rtl/serial_fifo_rx.sv - serial frame receiver feeding a local FIFO with sticky error flags
module serial_fifo_rx
  import serial_fifo_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_W       = 8,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic                  clk,
  input  logic                  kill,
  input  logic                  in_port,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              armed_q, armed_d;
  logic              sync1_q, s_in_q, s_prev_q;
  logic              overflow_q, overflow_d;
  logic              frame_err_q, frame_err_d;
  logic              push, ovf_set, ferr_set;
  logic              fifo_full;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    armed_d  = armed_q;
    push     = 1'b0;
    ovf_set  = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (s_in_q == IDLE_LVL) armed_d = 1'b1;
        // Arming stops a line stuck at the start level from retriggering.
        if (armed_q && s_prev_q == IDLE_LVL && s_in_q == START_BIT) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = (s_in_q == START_BIT) ? DATA : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shreg_d = {s_in_q, shreg_q[DATA_W-1:1]};
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (s_in_q == STOP_BIT) begin
            if (!fifo_full || rd_en) push    = 1'b1;
            else                     ovf_set = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set events take priority over a simultaneous clear.
  always_comb begin
    overflow_d  = clr_err ? 1'b0 : overflow_q;
    frame_err_d = clr_err ? 1'b0 : frame_err_q;
    if (ovf_set)  overflow_d  = 1'b1;
    if (ferr_set) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge kill) begin
    if (!kill) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      armed_q     <= 1'b0;
      sync1_q     <= 1'b1;
      s_in_q      <= 1'b1;
      s_prev_q    <= 1'b1;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      armed_q     <= armed_d;
      sync1_q     <= in_port;
      s_in_q      <= sync1_q;
      s_prev_q    <= s_in_q;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (kill),
    .wr_en    (push),
    .wr_data  (shreg_q),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (fifo_full),
    .empty    (empty),
    .count    (count)
  );

  assign full      = fifo_full;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_fifo_rx.sv
// tb/tb_serial_fifo_rx.sv - scoreboard bench for serial_fifo_rx
module tb_serial_fifo_rx;

  localparam int CPB   = 8;
  localparam int DW    = 8;
  localparam int DL2   = 2;
  localparam int FRAME = 10 * CPB;
  // Push edge counted from the negedge that drives the start bit.
  localparam int PUSH_EDGE = 2 + CPB / 2 + (DW + 1) * CPB + 1;

  logic           clk = 1'b0;
  logic           kill;
  logic           in_port;
  logic           rd_en;
  logic [DW-1:0]  rd_data;
  logic           rd_valid;
  logic           empty;
  logic           full;
  logic [DL2:0]   count;
  logic           clr_err;
  logic           overflow;
  logic           frame_err;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  serial_fifo_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (DW),
    .DEPTH_LOG2   (DL2)
  ) dut (
    .clk       (clk),
    .kill      (kill),
    .in_port   (in_port),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .clr_err   (clr_err),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #50 clk = ~clk;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_lvl, input logic pop_at_stop,
                            output logic [DL2:0] cnt_before, output logic [DL2:0] cnt_after,
                            output logic vld_after, output logic [DW-1:0] data_after);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == PUSH_EDGE - 1) cnt_before = count;
      if (i == PUSH_EDGE) begin
        cnt_after  = count;
        vld_after  = rd_valid;
        data_after = rd_data;
      end
      rd_en = (i == PUSH_EDGE - 1) ? pop_at_stop : 1'b0;
      if (i / CPB == 0)      in_port = 1'b0;
      else if (i / CPB <= DW) in_port = d[i/CPB-1];
      else                    in_port = stop_lvl;
    end
    @(negedge clk);
    in_port = 1'b1;
    rd_en   = 1'b0;
    idle(4);
  endtask

  task automatic do_read(output logic vld, output logic [DW-1:0] data);
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    vld  = rd_valid;
    data = rd_data;
  endtask

  task automatic test_reset;
    kill = 1'b0; in_port = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    #300;
    checks++;
    if ({empty, count, rd_valid, overflow, frame_err} !== {1'b1, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_during: empty=%b count=%0d rd_valid=%b ovf=%b ferr=%b want 1 0 0 0 0",
               empty, count, rd_valid, overflow, frame_err);
    end
    #210;
    kill = 1'b1;
    idle(4);
    checks++;
    if ({empty, full, count, rd_valid, overflow, frame_err} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_after: empty=%b full=%b count=%0d rd_valid=%b ovf=%b ferr=%b want 1 0 0 0 0 0",
               empty, full, count, rd_valid, overflow, frame_err);
    end
  endtask

  task automatic test_single;
    logic [DL2:0] cb, ca; logic v; logic [DW-1:0] d;
    send_frame(8'hA5, 1'b1, 1'b0, cb, ca, v, d);
    exp_q.push_back(8'hA5);
    checks++;
    if (cb !== 3'd0 || ca !== 3'd1) begin
      errors++;
      $display("FAIL single_latency: count before=%0d after=%0d want 0 1", cb, ca);
    end
    do_read(v, d);
    checks++;
    if (v !== 1'b1 || d !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL single_pop: rd_valid=%b rd_data=%h want 1 a5", v, d);
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_empty: empty=%b rd_valid=%b want 1 0", empty, rd_valid);
    end
    do_read(v, d);
    checks++;
    if (v !== 1'b0 || d !== 8'hA5) begin
      errors++;
      $display("FAIL empty_read: rd_valid=%b rd_data=%h want 0 a5", v, d);
    end
  endtask

  task automatic test_overflow;
    logic [DL2:0] cb, ca; logic v; logic [DW-1:0] d;
    for (int k = 1; k <= 5; k++) begin
      send_frame(DW'(k), 1'b1, 1'b0, cb, ca, v, d);
      if (k <= 4) exp_q.push_back(DW'(k));
      if (k == 4) begin
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL fill4: full=%b count=%0d ovf=%b want 1 4 0", full, count, overflow);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL overflow_set: ovf=%b count=%0d want 1 4", overflow, count);
    end
    for (int k = 0; k < 4; k++) begin
      logic [DW-1:0] e;
      do_read(v, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (v !== 1'b1 || d !== e) begin
        errors++;
        $display("FAIL ovf_drain%0d: rd_valid=%b rd_data=%h want 1 %h", k, v, d, e);
      end
    end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL overflow_clr: ovf=%b empty=%b want 0 1", overflow, empty);
    end
  endtask

  task automatic test_frame_err;
    logic [DL2:0] cb, ca; logic v; logic [DW-1:0] d;
    send_frame(8'h3C, 1'b0, 1'b0, cb, ca, v, d);
    checks++;
    if (frame_err !== 1'b1 || ca !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_set: ferr=%b count=%0d ovf=%b want 1 0 0", frame_err, ca, overflow);
    end
    send_frame(8'h55, 1'b1, 1'b0, cb, ca, v, d);
    exp_q.push_back(8'h55);
    checks++;
    if (ca !== 3'd1) begin
      errors++;
      $display("FAIL after_ferr_count: count=%0d want 1", ca);
    end
    do_read(v, d);
    checks++;
    if (v !== 1'b1 || d !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL after_ferr_pop: rd_valid=%b rd_data=%h want 1 55", v, d);
    end
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_clr: ferr=%b want 0", frame_err);
    end
  endtask

  task automatic test_glitch;
    logic [DL2:0] cb, ca; logic v; logic [DW-1:0] d;
    @(negedge clk); in_port = 1'b0;
    idle(2);
    in_port = 1'b1;
    idle(3 * CPB);
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL glitch: count=%0d empty=%b ovf=%b ferr=%b want 0 1 0 0", count, empty, overflow, frame_err);
    end
    send_frame(8'h5A, 1'b1, 1'b0, cb, ca, v, d);
    exp_q.push_back(8'h5A);
    do_read(v, d);
    checks++;
    if (ca !== 3'd1 || v !== 1'b1 || d !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL post_glitch_frame: count=%0d rd_valid=%b rd_data=%h want 1 1 5a", ca, v, d);
    end
  endtask

  task automatic test_full_push_pop;
    logic [DL2:0] cb, ca; logic v; logic [DW-1:0] d, e;
    logic [DW-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (words[k]) begin
      send_frame(words[k], 1'b1, 1'b0, cb, ca, v, d);
      exp_q.push_back(words[k]);
    end
    send_frame(8'h77, 1'b1, 1'b1, cb, ca, v, d);
    e = exp_q.pop_front();
    exp_q.push_back(8'h77);
    checks++;
    if (cb !== 3'd4 || ca !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: count before=%0d after=%0d ovf=%b want 4 4 0", cb, ca, overflow);
    end
    checks++;
    if (v !== 1'b1 || d !== e) begin
      errors++;
      $display("FAIL full_pop_data: rd_valid=%b rd_data=%h want 1 %h", v, d, e);
    end
    for (int k = 0; k < 4; k++) begin
      do_read(v, d);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++;
      if (v !== 1'b1 || d !== e) begin
        errors++;
        $display("FAIL full_drain%0d: rd_valid=%b rd_data=%h want 1 %h", k, v, d, e);
      end
    end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_end: empty=%b ovf=%b want 1 0", empty, overflow);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_frame_err;
    test_glitch;
    test_full_push_pop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
